// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) feeding the scanning display.
// Optional leading-zero blanking is enabled by defining BCD_BLANK_EN.
module bin2bcd_seq #(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int WORK_W = 4*DIGITS + 4;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic [63:0] f_pow10(input int n);
    logic [63:0] acc;
    acc = 64'd1;
    for (int i = 0; i < n; i++) begin
      acc = acc * 64'd10;
    end
    return acc;
  endfunction

  localparam logic [63:0]         LP_MAX = f_pow10(DIGITS) - 64'd1;
  localparam logic [4*DIGITS-1:0] LP_SAT = {DIGITS{4'h9}};

  // Every nibble (spare one included) that is 5 or more gets +3 before the shift.
  function automatic logic [WORK_W-1:0] f_add3(input logic [WORK_W-1:0] work);
    logic [WORK_W-1:0] res;
    res = work;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (res[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = res[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = res[4*i +: 4];
      end
    end
    return res;
  endfunction

`ifdef BCD_BLANK_EN
  // Zero nibbles above the most significant non-zero digit become 4'hF; digit 0 is kept.
  function automatic logic [4*DIGITS-1:0] f_blank(input logic [4*DIGITS-1:0] bcd);
    logic [4*DIGITS-1:0] res;
    logic                leading;
    res     = bcd;
    leading = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (leading && (bcd[4*i +: 4] == 4'd0)) begin
        res[4*i +: 4] = 4'hF;
      end else begin
        leading = 1'b0;
      end
    end
    return res;
  endfunction
`endif

  logic [1:0]          r_state;
  logic [BIN_W-1:0]    r_bin_shift;
  logic [WORK_W-1:0]   r_work;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf_next;
  logic                r_busy;
  logic                r_done;
  logic [4*DIGITS-1:0] r_bcd_out;
  logic                r_ovf;

  logic [63:0]         w_bin_ext;
  logic                w_ovf_in;
  logic [WORK_W-1:0]   w_work_adj;
  logic [WORK_W-1:0]   w_work_next;
  logic [BIN_W-1:0]    w_bin_next;
  logic                w_last;
  logic [4*DIGITS-1:0] w_bcd_plain;
  logic [4*DIGITS-1:0] w_bcd_load;

  // Next-value datapath: adjust, shift, last-shift detect and output formatting.
  always_comb begin
    w_bin_ext   = 64'(bin_in);
    w_ovf_in    = (w_bin_ext > LP_MAX);
    w_work_adj  = f_add3(r_work);
    w_work_next = (w_work_adj << 1) | WORK_W'(r_bin_shift[BIN_W-1]);
    w_bin_next  = r_bin_shift << 1;
    w_last      = (r_cnt == CNT_W'(BIN_W - 1));
    w_bcd_plain = w_work_next[4*DIGITS-1:0];
    if (r_ovf_next) begin
      w_bcd_load = LP_SAT;
    end else begin
`ifdef BCD_BLANK_EN
      w_bcd_load = f_blank(w_bcd_plain);
`else
      w_bcd_load = w_bcd_plain;
`endif
    end
  end

  // Control FSM with busy/done flags; done is raised on the edge entering DONE.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= ST_SHIFT;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (w_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_SHIFT;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Conversion datapath: load on accepted start, shift once per SHIFT cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_bin_shift <= '0;
      r_work      <= '0;
      r_cnt       <= '0;
      r_ovf_next  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_bin_shift <= bin_in;
            r_work      <= '0;
            r_cnt       <= '0;
            r_ovf_next  <= w_ovf_in;
          end else begin
            r_bin_shift <= r_bin_shift;
            r_work      <= r_work;
            r_cnt       <= r_cnt;
            r_ovf_next  <= r_ovf_next;
          end
        end
        ST_SHIFT: begin
          r_bin_shift <= w_bin_next;
          r_work      <= w_work_next;
          r_cnt       <= r_cnt + CNT_W'(1);
        end
        ST_DONE: begin
          r_cnt <= '0;
        end
        default: begin
          r_bin_shift <= '0;
          r_work      <= '0;
          r_cnt       <= '0;
          r_ovf_next  <= 1'b0;
        end
      endcase
    end
  end

  // Result registers change only on the edge that enters DONE.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_bcd_out <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if ((r_state == ST_SHIFT) && w_last) begin
        r_bcd_out <= w_bcd_load;
        r_ovf     <= r_ovf_next;
      end else begin
        r_bcd_out <= r_bcd_out;
        r_ovf     <= r_ovf;
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign bcd_out = r_bcd_out;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed, randomized, handshake, back-to-back and reset tests.
module tb_bin2bcd_seq;

  localparam int      BIN_W  = 27;
  localparam int      DIGITS = 8;
  localparam longint  MAXV   = 64'd99999999;
  localparam int      LAT    = BIN_W + 1;

  logic              sys_clk;
  logic              sys_rst_n;
  logic              start;
  logic [BIN_W-1:0]  bin_in;
  logic              busy;
  logic              done;
  logic [31:0]       bcd_out;
  logic              ovf;

  int checks = 0;
  int errors = 0;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
    .ovf       (ovf)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: decimal digits by division, saturation, optional blanking by digit count.
  function automatic logic [31:0] model_bcd(input longint v);
    logic [31:0] r;
    longint      p;
    int          nd;
    r = 32'h0;
    if (v > MAXV) begin
      r = 32'h99999999;
    end else begin
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
        r[4*i +: 4] = 4'((v / p) % 10);
        p = p * 10;
      end
`ifdef BCD_BLANK_EN
      nd = 1;
      p  = 10;
      while (nd < DIGITS && v >= p) begin
        nd++;
        p = p * 10;
      end
      for (int i = nd; i < DIGITS; i++) r[4*i +: 4] = 4'hF;
`else
      nd = 0;
`endif
    end
    return r;
  endfunction

  // Drives one start at cycle 0 and returns the cycle at which done is seen (-1 on timeout).
  task automatic convert(input logic [BIN_W-1:0] v, output int lat);
    @(negedge sys_clk);
    start  = 1'b1;
    bin_in = v;
    @(negedge sys_clk);
    start  = 1'b0;
    bin_in = BIN_W'($urandom);
    lat = -1;
    for (int c = 1; c <= 80; c++) begin
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    start     = 1'b0;
    bin_in    = '0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (bcd_out !== 32'h0) begin errors++; $display("FAIL reset_bcd: got %h expected 00000000", bcd_out); end
  endtask

  task automatic test_value(input logic [BIN_W-1:0] v);
    int          lat;
    logic [31:0] exp_bcd;
    logic        exp_ovf;
    exp_bcd = model_bcd(longint'(v));
    exp_ovf = (longint'(v) > MAXV);
    convert(v, lat);
    checks++; if (lat != LAT) begin errors++; $display("FAIL latency(%0d): got %0d expected %0d", v, lat, LAT); end
    checks++; if (bcd_out !== exp_bcd) begin errors++; $display("FAIL bcd(%0d): got %h expected %h", v, bcd_out, exp_bcd); end
    checks++; if (ovf !== exp_ovf) begin errors++; $display("FAIL ovf(%0d): got %b expected %b", v, ovf, exp_ovf); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done(%0d): got %b expected 0", v, busy); end
    @(negedge sys_clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse(%0d): got %b expected 0", v, done); end
    checks++; if (bcd_out !== exp_bcd) begin errors++; $display("FAIL bcd_hold(%0d): got %h expected %h", v, bcd_out, exp_bcd); end
  endtask

  task automatic test_directed();
    logic [BIN_W-1:0] vals [10];
    vals = '{27'd0, 27'd12345678, 27'd305, 27'd99999999, 27'd100000000,
             27'd134217727, 27'd1, 27'd9, 27'd10, 27'd10000000};
    foreach (vals[i]) test_value(vals[i]);
  endtask

  task automatic test_random();
    logic [BIN_W-1:0] v;
    for (int i = 0; i < 30; i++) begin
      case (i % 3)
        0: v = BIN_W'($urandom_range(134217727, 0));
        1: v = BIN_W'($urandom_range(99999999, 0));
        default: v = BIN_W'($urandom_range(999, 0));
      endcase
      test_value(v);
    end
  endtask

  task automatic test_ignore_start();
    int n_done = 0;
    int first  = -1;
    @(negedge sys_clk);
    start  = 1'b1;
    bin_in = 27'd5;
    for (int c = 1; c <= 70; c++) begin
      @(negedge sys_clk);
      if (done === 1'b1) begin
        n_done++;
        if (first < 0) first = c;
        checks++; if (bcd_out !== model_bcd(64'd5)) begin errors++; $display("FAIL ignore_bcd: got %h expected %h", bcd_out, model_bcd(64'd5)); end
      end
      start  = (c == 3 || c == 28);
      bin_in = 27'd7;
    end
    start = 1'b0;
    checks++; if (n_done != 1) begin errors++; $display("FAIL ignore_count: got %0d expected 1", n_done); end
    checks++; if (first != LAT) begin errors++; $display("FAIL ignore_cycle: got %0d expected %0d", first, LAT); end
  endtask

  task automatic test_back_to_back();
    int cyc [$];
    @(negedge sys_clk);
    start  = 1'b1;
    bin_in = 27'd42;
    for (int c = 1; c <= 70; c++) begin
      @(negedge sys_clk);
      if (done === 1'b1) begin
        cyc.push_back(c);
        if (c < 40) begin
          checks++; if (bcd_out !== model_bcd(64'd42)) begin errors++; $display("FAIL b2b_first: got %h expected %h", bcd_out, model_bcd(64'd42)); end
        end else begin
          checks++; if (bcd_out !== model_bcd(64'd43)) begin errors++; $display("FAIL b2b_second: got %h expected %h", bcd_out, model_bcd(64'd43)); end
        end
      end
      start  = (c == 29);
      bin_in = 27'd43;
    end
    start = 1'b0;
    checks++; if (cyc.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", cyc.size()); end
    if (cyc.size() == 2) begin
      checks++; if (cyc[0] != LAT) begin errors++; $display("FAIL b2b_cycle0: got %0d expected %0d", cyc[0], LAT); end
      checks++; if (cyc[1] != 2*LAT + 1) begin errors++; $display("FAIL b2b_cycle1: got %0d expected %0d", cyc[1], 2*LAT + 1); end
    end
  endtask

  task automatic test_async_reset();
    int n_done = 0;
    test_value(27'd100000000);
    @(negedge sys_clk);
    start  = 1'b1;
    bin_in = 27'd777;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (9) @(negedge sys_clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before: got %b expected 1", busy); end
    #2 sys_rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
    checks++; if (bcd_out !== 32'h0) begin errors++; $display("FAIL rst_bcd: got %h expected 00000000", bcd_out); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge sys_clk);
      if (done === 1'b1) n_done++;
    end
    checks++; if (n_done != 0) begin errors++; $display("FAIL rst_no_done: got %0d expected 0", n_done); end
    test_value(27'd777);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
